// File: rtl/logic_gates_tester_pkg.sv
// Shared types and golden truth table for the 3-input logic-gate tester.
package logic_gates_tester_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} lgt_state_t;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  // Bit i is the expected output for input vector {a,b,c} == i.
  localparam logic [NUM_VEC-1:0] EXP_X  = 8'b1001_0101;
  localparam logic [NUM_VEC-1:0] EXP_Y1 = 8'b1100_0000;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [3:0]       MAX_ERR  = 4'(NUM_VEC);

  function automatic logic vec_mismatch(input logic [VEC_W-1:0] vec,
                                        input logic             x,
                                        input logic             y1);
    return (x != EXP_X[vec]) || (y1 != EXP_Y1[vec]);
  endfunction

endpackage

// File: rtl/logic_gates_tester_settle_timer.sv
// Hold counter: counts enabled cycles since the last clear and flags the
// final settle cycle so the caller can move on to sampling.
module settle_timer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/logic_gates_tester.sv
// Sweeps all eight {a,b,c} vectors into the gate block, checks x/y1 against
// the golden table and accumulates an error count and per-vector fail mask.
module logic_gates_tester
  import logic_gates_tester_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       x_in,
  input  logic       y1_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask
);

  lgt_state_t       state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [VEC_W-1:0] abc_q, abc_d;
  logic [3:0]       err_q, err_d;
  logic [7:0]       mask_q, mask_d;
  logic             pass_q, pass_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;
  logic mismatch;

  settle_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expired_o(timer_expired)
  );

  // Only consulted in SAMPLE, so DRIVE-time glitches never reach the results.
  assign mismatch = vec_mismatch(vec_q, x_in, y1_in);

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    abc_d       = abc_q;
    err_d       = err_q;
    mask_d      = mask_q;
    pass_d      = pass_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        abc_d       = '0;
        if (start) begin
          err_d   = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          state_d = DRIVE;
        end
      end

      DRIVE: begin
        timer_en = 1'b1;
        if (timer_expired) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        timer_clear = 1'b1;
        if (mismatch) begin
          mask_d[vec_q] = 1'b1;
          if (err_q != MAX_ERR) begin
            err_d = err_q + 4'd1;
          end
        end
        // The stimulus register steps together with the vector so a,b,c
        // change exactly on DRIVE entry and return to zero for DONE.
        if (vec_q == LAST_VEC) begin
          abc_d   = '0;
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          abc_d   = vec_q + 3'd1;
          state_d = DRIVE;
        end
      end

      DONE: begin
        abc_d   = '0;
        pass_d  = (err_q == 4'd0);
        state_d = IDLE;
      end

      default: begin
        abc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      abc_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      abc_q   <= abc_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  assign {a, b, c}  = abc_q;
  assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_mask  = mask_q;

endmodule

// File: tb/tb_logic_gates_tester.sv
// Directed bench: the tester drives a behavioural gate model with selectable
// faults; expected results come from hand-computed vector tables.
module tb_logic_gates_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic       a0, b0, c0, x0, y10, busy0, done0, pass0;
  logic       a1, b1, c1, x1, y11, busy1, done1, pass1;
  logic [3:0] err0, err1;
  logic [7:0] mask0, mask1;

  int   fault_mode;
  logic glitch;

  int n_checks = 0;
  int n_fail   = 0;

  // Gate block model: 0 clean, 1 x stuck at 0, 2 y1 inverted, 3 clean
  // (mode 3 is used with the glitch flag that corrupts DRIVE cycles only).
  always_comb begin
    x0  = (a0 & b0) ^ ~c0;
    y10 = a0 & b0;
    case (fault_mode)
      1:       x0  = 1'b0;
      2:       y10 = ~(a0 & b0);
      default: ;
    endcase
    if (glitch) begin
      x0  = ~x0;
      y10 = ~y10;
    end
  end

  assign x1  = (a1 & b1) ^ ~c1;
  assign y11 = a1 & b1;

  logic_gates_tester #(.HOLD_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .a(a0), .b(b0), .c(c0), .x_in(x0), .y1_in(y10),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(mask0)
  );

  logic_gates_tester #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .x_in(x1), .y1_in(y11),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1)
  );

  typedef struct {
    string      name;
    int         mode;
    int         poke_k;
    logic [3:0] err;
    logic [7:0] mask;
    logic       pass;
  } sweep_t;

  sweep_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_abc"},  {29'd0, a0, b0, c0}, 0);
    chk({tag, "_busy"}, {31'd0, busy0}, 0);
    chk({tag, "_done"}, {31'd0, done0}, 0);
    chk({tag, "_pass"}, {31'd0, pass0}, 0);
    chk({tag, "_err"},  {28'd0, err0}, 0);
    chk({tag, "_mask"}, {24'd0, mask0}, 0);
  endtask

  // HOLD_CYCLES=2: cycle k (1..24) after the start edge drives vector (k-1)/3,
  // the third cycle of each group samples, and cycle 25 is the done pulse.
  task automatic run_sweep(input sweep_t s);
    fault_mode = s.mode;
    glitch     = 1'b0;
    start0     = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      glitch = (s.mode == 3) && (((k - 1) % 3) != 2);
      start0 = (k == s.poke_k);
      chk({s.name, "_abc"},  {29'd0, a0, b0, c0}, (k - 1) / 3);
      chk({s.name, "_busy"}, {31'd0, busy0}, 1);
      chk({s.name, "_done_early"}, {31'd0, done0}, 0);
      if (k == 1) begin
        chk({s.name, "_clear_err"},  {28'd0, err0}, 0);
        chk({s.name, "_clear_mask"}, {24'd0, mask0}, 0);
        chk({s.name, "_clear_pass"}, {31'd0, pass0}, 0);
      end
      tick();
    end
    glitch = 1'b0;
    start0 = (s.poke_k == 25);
    chk({s.name, "_done"},      {31'd0, done0}, 1);
    chk({s.name, "_done_busy"}, {31'd0, busy0}, 0);
    chk({s.name, "_done_abc"},  {29'd0, a0, b0, c0}, 0);
    chk({s.name, "_done_err"},  {28'd0, err0}, {28'd0, s.err});
    chk({s.name, "_done_mask"}, {24'd0, mask0}, {24'd0, s.mask});
    tick();
    start0 = 1'b0;
    for (int k = 26; k <= 27; k++) begin
      chk({s.name, "_post_done"}, {31'd0, done0}, 0);
      chk({s.name, "_post_busy"}, {31'd0, busy0}, 0);
      chk({s.name, "_pass"},      {31'd0, pass0}, {31'd0, s.pass});
      chk({s.name, "_err"},       {28'd0, err0}, {28'd0, s.err});
      chk({s.name, "_mask"},      {24'd0, mask0}, {24'd0, s.mask});
      tick();
    end
    $display("sweep %-14s err_count=%0d fail_mask=%02h pass=%0d", s.name, err0, mask0, pass0);
  endtask

  initial begin
    tbl[0] = '{"clean",         0, -1, 4'd0, 8'h00, 1'b1};
    tbl[1] = '{"x_stuck0",      1, -1, 4'd4, 8'h95, 1'b0};
    tbl[2] = '{"y1_inv",        2, -1, 4'd8, 8'hFF, 1'b0};
    tbl[3] = '{"y1_inv_rerun",  2, -1, 4'd8, 8'hFF, 1'b0};
    tbl[4] = '{"start_mid",     1, 10, 4'd4, 8'h95, 1'b0};
    tbl[5] = '{"drive_glitch",  3, -1, 4'd0, 8'h00, 1'b1};
    tbl[6] = '{"start_in_done", 0, 25, 4'd0, 8'h00, 1'b1};

    rst        = 1'b1;
    start0     = 1'b0;
    start1     = 1'b0;
    fault_mode = 0;
    glitch     = 1'b0;
    repeat (3) tick();
    chk_reset_values("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_sweep(tbl[i]);
    end

    // Reset while vector 5 is on the pins: partial results must vanish.
    begin
      int seen_done;
      fault_mode = 1;
      start0     = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (15) tick();
      chk("midrst_abc_before",  {29'd0, a0, b0, c0}, 5);
      chk("midrst_mask_before", {24'd0, mask0}, 32'h15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_values("midrst");
      seen_done = 0;
      for (int k = 0; k < 30; k++) begin
        tick();
        if (done0 || busy0) seen_done++;
      end
      chk("midrst_no_done", seen_done, 0);
      $display("mid-sweep reset: outputs cleared, idle cycles with activity=%0d", seen_done);
      run_sweep(tbl[0]);
    end

    // HOLD_CYCLES=1 with start held high: 16 busy cycles, done, one IDLE cycle.
    begin
      int t;
      start1 = 1'b1;
      t = 0;
      while (!done1 && t < 100) begin
        tick();
        t++;
      end
      chk("hold1_first_done", {31'd0, done1}, 1);
      for (int s = 0; s < 3; s++) begin
        tick();
        chk("hold1_idle_busy", {31'd0, busy1}, 0);
        chk("hold1_idle_done", {31'd0, done1}, 0);
        chk("hold1_idle_abc",  {29'd0, a1, b1, c1}, 0);
        chk("hold1_pass",      {31'd0, pass1}, 1);
        chk("hold1_err",       {28'd0, err1}, 0);
        chk("hold1_mask",      {24'd0, mask1}, 0);
        for (int j = 0; j < 16; j++) begin
          tick();
          chk("hold1_abc",  {29'd0, a1, b1, c1}, j / 2);
          chk("hold1_busy", {31'd0, busy1}, 1);
          chk("hold1_done_early", {31'd0, done1}, 0);
        end
        tick();
        chk("hold1_done", {31'd0, done1}, 1);
        $display("hold1 sweep %0d: done after 18-cycle period, pass=%0d", s, pass1);
      end
      start1 = 1'b0;
      repeat (3) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
